// File: rtl/line_window_ctrl.sv
`default_nettype none
// ============================================================================
//  line_window_ctrl
//  Ring of KERNEL_SIZE+1 line slots feeding a KxK sliding window generator,
//  ready/valid on both the pixel input and the window output.
//  Revision: 1.0
// ============================================================================
module line_window_ctrl #(
   parameter int INTEGER_BITS     = 9,
   parameter int FIXED_POINT_BITS = 4,
   parameter int IMG_WIDTH        = 512,
   parameter int IMG_HEIGHT       = 512,
   parameter int KERNEL_SIZE      = 3
) (
   input  logic                                                            i_clk,
   input  logic                                                            i_rst_n,
   input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]                        i_pixel_data,
   input  logic                                                            i_pixel_data_valid,
   output logic                                                            o_pixel_data_ready,
   output logic [(INTEGER_BITS+FIXED_POINT_BITS)*KERNEL_SIZE*KERNEL_SIZE-1:0] o_window_data,
   output logic                                                            o_window_data_valid,
   input  logic                                                            i_window_data_ready,
   output logic                                                            o_intr,
   output logic                                                            o_frame_done
);

   localparam int DW    = INTEGER_BITS + FIXED_POINT_BITS;
   localparam int K     = KERNEL_SIZE;
   localparam int WINW  = DW * K * K;
   localparam int NSLOT = K + 1;
   localparam int SW    = $clog2(NSLOT);
   localparam int LW    = $clog2(K + 2);
   localparam int AW    = $clog2(IMG_WIDTH);
   localparam int CW    = $clog2(IMG_WIDTH + 1);
   localparam int HW    = $clog2(IMG_HEIGHT);

   localparam logic [AW-1:0] C_COL_LAST  = AW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] C_COL_END   = CW'(IMG_WIDTH);
   localparam logic [CW-1:0] C_WIN_FIRST = CW'(K - 1);
   localparam logic [HW-1:0] C_ROW_LAST  = HW'(IMG_HEIGHT - 1);
   localparam logic [HW-1:0] C_BAND_LAST = HW'(IMG_HEIGHT - K);
   localparam logic [LW-1:0] C_ONE_LINE  = LW'(1);
   localparam logic [LW-1:0] C_K_LINES   = LW'(K);
   localparam logic [LW-1:0] C_ALL_LINES = LW'(K + 1);
   localparam logic [SW-1:0] C_SLOT_ONE  = SW'(1);
   localparam logic [SW-1:0] C_SLOT_K    = SW'(K);
   localparam logic [SW:0]   C_NSLOT     = (SW+1)'(NSLOT);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_READ = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_col_q, wr_col_d;
   logic [SW-1:0]   wr_slot_q, wr_slot_d;
   logic [SW-1:0]   base_q, base_d;
   logic [HW-1:0]   in_row_q, in_row_d;
   logic [HW-1:0]   out_row_q, out_row_d;
   logic [LW-1:0]   lines_full_q, lines_full_d;
   logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]   sh_cnt_q, sh_cnt_d;
   logic            rdata_valid_q, rdata_valid_d;
   logic [WINW-1:0] win_q, win_d;
   logic            win_valid_q, win_valid_d;
   logic            intr_q, intr_d;
   logic            frame_done_q, frame_done_d;
   logic            ready_q, ready_d;

   logic            px_accept, line_done, shift, issue, win_accept, band_end, last_band;
   logic [LW-1:0]   freed;
   logic [DW-1:0]   slot_rd  [NSLOT];
   logic [DW-1:0]   col_data [K];

   function automatic logic [SW-1:0] slot_add(input logic [SW-1:0] b, input logic [SW-1:0] n);
      logic [SW:0] s;
      s = {1'b0, b} + {1'b0, n};
      if (s >= C_NSLOT) s = s - C_NSLOT;
      return s[SW-1:0];
   endfunction

   assign px_accept  = i_pixel_data_valid && ready_q;
   assign line_done  = px_accept && (wr_col_q == C_COL_LAST);
   // A column moves into the window when the window is empty or being consumed.
   assign shift      = rdata_valid_q && (!win_valid_q || i_window_data_ready);
   assign issue      = (state_q == ST_READ) && (rd_cnt_q != C_COL_END) && (!rdata_valid_q || shift);
   assign win_accept = win_valid_q && i_window_data_ready;
   assign band_end   = win_accept && (sh_cnt_q == C_COL_END);
   assign last_band  = (out_row_q == C_BAND_LAST);

   generate
      for (genvar s = 0; s < NSLOT; s++) begin : g_slot
         logic [DW-1:0] mem [IMG_WIDTH];
         logic [DW-1:0] rd_q;
         always_ff @(posedge i_clk) begin
            if (px_accept && (wr_slot_q == SW'(s))) mem[wr_col_q] <= i_pixel_data;
            if (issue) rd_q <= mem[rd_cnt_q[AW-1:0]];
         end
         assign slot_rd[s] = rd_q;
      end
   endgenerate

   always_comb begin
      for (int r = 0; r < K; r++) begin
         col_data[r] = slot_rd[slot_add(base_q, SW'(r))];
      end
   end

   always_comb begin
      wr_col_d      = wr_col_q;
      wr_slot_d     = wr_slot_q;
      in_row_d      = in_row_q;
      state_d       = state_q;
      rd_cnt_d      = rd_cnt_q;
      sh_cnt_d      = sh_cnt_q;
      rdata_valid_d = rdata_valid_q;
      win_d         = win_q;
      win_valid_d   = win_valid_q;
      base_d        = base_q;
      out_row_d     = out_row_q;
      intr_d        = band_end;
      frame_done_d  = band_end && last_band;
      freed         = '0;

      if (px_accept) begin
         if (line_done) begin
            wr_col_d  = '0;
            wr_slot_d = slot_add(wr_slot_q, C_SLOT_ONE);
            in_row_d  = (in_row_q == C_ROW_LAST) ? '0 : in_row_q + 1'b1;
         end else begin
            wr_col_d  = wr_col_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: if (lines_full_q >= C_K_LINES) state_d = ST_READ;
         ST_READ: if (band_end) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (issue) begin
         rd_cnt_d      = rd_cnt_q + 1'b1;
         rdata_valid_d = 1'b1;
      end else if (shift) begin
         rdata_valid_d = 1'b0;
      end

      if (shift) begin
         sh_cnt_d    = sh_cnt_q + 1'b1;
         win_valid_d = (sh_cnt_q >= C_WIN_FIRST);
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_d[(r*K+c)*DW +: DW] = win_q[(r*K+c+1)*DW +: DW];
            end
            win_d[(r*K+K-1)*DW +: DW] = col_data[r];
         end
      end else if (win_accept) begin
         win_valid_d = 1'b0;
      end

      // The final band of a frame releases all K lines so frames never mix.
      if (band_end) begin
         rd_cnt_d  = '0;
         sh_cnt_d  = '0;
         freed     = last_band ? C_K_LINES : C_ONE_LINE;
         base_d    = slot_add(base_q, last_band ? C_SLOT_K : C_SLOT_ONE);
         out_row_d = last_band ? '0 : out_row_q + 1'b1;
      end

      lines_full_d = lines_full_q + {{(LW-1){1'b0}}, line_done} - freed;
      ready_d      = (lines_full_d < C_ALL_LINES);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= ST_IDLE;
         wr_col_q      <= '0;
         wr_slot_q     <= '0;
         in_row_q      <= '0;
         base_q        <= '0;
         out_row_q     <= '0;
         lines_full_q  <= '0;
         rd_cnt_q      <= '0;
         sh_cnt_q      <= '0;
         rdata_valid_q <= 1'b0;
         win_q         <= '0;
         win_valid_q   <= 1'b0;
         intr_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         ready_q       <= 1'b1;
      end else begin
         state_q       <= state_d;
         wr_col_q      <= wr_col_d;
         wr_slot_q     <= wr_slot_d;
         in_row_q      <= in_row_d;
         base_q        <= base_d;
         out_row_q     <= out_row_d;
         lines_full_q  <= lines_full_d;
         rd_cnt_q      <= rd_cnt_d;
         sh_cnt_q      <= sh_cnt_d;
         rdata_valid_q <= rdata_valid_d;
         win_q         <= win_d;
         win_valid_q   <= win_valid_d;
         intr_q        <= intr_d;
         frame_done_q  <= frame_done_d;
         ready_q       <= ready_d;
      end
   end

   assign o_pixel_data_ready  = ready_q;
   assign o_window_data       = win_q;
   assign o_window_data_valid = win_valid_q;
   assign o_intr              = intr_q;
   assign o_frame_done        = frame_done_q;

endmodule
`default_nettype wire
